ycbcr_packer: RTL
=================

Name: ycbcr_packer

Overview:
- Transmit-side producer for the pixel FIFO.
- Takes 24-bit RGB pixels with DE/VSYNC timing from the HDMI receive path and converts each pixel to 4:2:2 YCbCr (BT.601, studio range).
- Packs each pixel into the 29-bit FIFO word format that the display-side controller reads back.
- Writes words into the async pixel FIFO, counts active lines and half-line blocks, and flags overflow.

Parameters:
- ACTIVE_WIDTH, 1280, pixels per active line that are written; pixels beyond this are discarded.
- HALF_WIDTH, 640, pixel index at which the x block switches from 0 to 1.
- MAX_LINES, 720, active lines per frame that are written; later lines are discarded.

Ports:
- i_clk_74M  input  1  74.25 MHz pixel clock
- i_rst  input  1  synchronous active-high reset
- i_de  input  1  data enable from the receiver
- i_vsync  input  1  vertical sync, active-high
- i_r  input  8  red
- i_g  input  8  green
- i_b  input  8  blue
- fifo_full  input  1  FIFO full flag
- fifo_write  output  1  FIFO write strobe
- data  output  29  FIFO word
- o_overflow  output  1  sticky overflow flag for the current frame
- o_drop_cnt  output  16  saturating count of dropped words

Behaviour:
- Clock and reset: one clock (i_clk_74M); i_rst is synchronous, active-high.
- Reset values: fifo_write=0, data=0, o_overflow=0, o_drop_cnt=0, FSM=SYNC, all counters 0.
- Word format:
  - data[28:27] = x_count = {frame_parity, xblock}.
  - data[26:16] = line index (11 bits).
  - data[15:8] = Y.
  - data[7:0] = C: Cr when pixel index is even, Cb when odd.
- Conversion, 8-bit unsigned in, signed 18-bit intermediates, arithmetic shift right:
  - Y = ((66R + 129G + 25B + 128) >>> 8) + 16
  - Cb = ((-38R - 74G + 112B + 128) >>> 8) + 128
  - Cr = ((112R - 94G - 18B + 128) >>> 8) + 128
  - Each result is clamped to 0..255.
- Pipeline:
  - Stage 1 registers the products.
  - Stage 2 registers the sums and clamps.
  - Stage 3 registers data and fifo_write.
  - Latency from pixel at input to fifo_write = 3 cycles.
  - Pixel index, line index and xblock are pipelined alongside the data.
- FSM:
  - SYNC: wait for a rising edge of i_vsync; ignore DE. Then go to WAIT_LINE, line=0, toggle frame_parity.
  - WAIT_LINE: on i_de=1, go to ACTIVE with pixel=0. A rising edge of i_vsync restarts the frame (line=0, parity toggles, o_overflow cleared).
  - ACTIVE: each cycle with i_de=1, pixel++. If pixel<ACTIVE_WIDTH and line<MAX_LINES, the pixel is valid. On i_de=0, go to WAIT_LINE and line++; line saturates at 2047.
- xblock = (pixel >= HALF_WIDTH).
- A rising edge of i_vsync while in ACTIVE aborts the line:
  - Go to WAIT_LINE with line=0.
  - Pixels already in the pipeline still drain.
- FIFO full:
  - Evaluated at stage 3. If a valid word arrives while fifo_full=1: fifo_write=0, the word is dropped, o_overflow=1, and o_drop_cnt increments, saturating at 16'hFFFF.
  - No back-pressure on the input.
- o_drop_cnt is cleared only by i_rst.
- Reset mid-line: the pipeline is flushed; no partial word is written after reset.

Optional Feature:
- Macro CHROMA_AVG_EN.
- Defined:
  - Cb/Cr are averaged over each even/odd pixel pair: (C_even + C_odd + 1) >> 1.
  - The even word carries the averaged Cr; the odd word carries the averaged Cb.
  - Adds one pipeline stage; latency = 4 cycles.
  - An unpaired last pixel uses its own chroma.
- Undefined: chroma is taken from the same pixel, latency = 3.

Test Plan:
- Reset, then vsync pulse and one line of 1280 white pixels (255,255,255) -> 1280 writes, Y=235, C=128, y_count=0; x_count[0]=0 for the first 640 words and 1 for the rest; first write 3 cycles after first DE.
- Red pixel (255,0,0) at even index followed by red at odd index -> words Y=82/C=240 (Cr), then Y=82/C=90 (Cb).
- Black line as the second line after vsync -> Y=16, C=128, y_count=1; next vsync -> y_count=0 and x_count[1] toggled.
- Hold fifo_full=1 for 10 valid pixels -> no fifo_write, o_drop_cnt=10, o_overflow=1; o_overflow=0 after the next vsync, o_drop_cnt stays 10.
- Line with 1300 DE cycles and frame with 730 lines -> exactly 1280 writes per line; no writes for lines 720..729.
- Assert i_rst mid-line -> fifo_write=0 from the next cycle; nothing is written until a new vsync plus DE.

Source files
------------

// File: rtl/ycbcr_packer.sv
// ---------------------------------------------------------------------------
// ycbcr_packer
//
// Transmit-side producer for the pixel FIFO. RGB pixels qualified by DE/VSYNC
// are converted to 4:2:2 YCbCr (BT.601 studio range), packed into a 29-bit
// word and written into the async pixel FIFO. Words that meet a full FIFO are
// dropped and counted; there is no back-pressure toward the receiver.
//
// Word layout:
//   data[28]    frame parity (toggles on every frame start)
//   data[27]    x block (0 for pixel < HALF_WIDTH, 1 otherwise)
//   data[26:16] line index
//   data[15:8]  Y
//   data[7:0]   Cr on even pixel indices, Cb on odd pixel indices
//
// Ports:
//   i_clk_74M   pixel clock
//   i_rst       synchronous active-high reset, flushes the pipeline
//   i_de        data enable from the receiver
//   i_vsync     vertical sync, active-high (rising edge starts a frame)
//   i_r/i_g/i_b 8-bit RGB pixel
//   fifo_full   FIFO full flag, sampled in the last pipeline stage
//   fifo_write  FIFO write strobe
//   data        FIFO word
//   o_overflow  sticky drop flag, cleared at the next frame start
//   o_drop_cnt  saturating count of dropped words, cleared only by reset
//
// Build option: define CHROMA_AVG_EN to average chroma over each even/odd
// pixel pair. This adds one pipeline stage (latency 4 instead of 3).
// ---------------------------------------------------------------------------
module ycbcr_packer #(
    parameter int ACTIVE_WIDTH = 1280,
    parameter int HALF_WIDTH   = 640,
    parameter int MAX_LINES    = 720
) (
    input  logic        i_clk_74M,
    input  logic        i_rst,
    input  logic        i_de,
    input  logic        i_vsync,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    input  logic        fifo_full,
    output logic        fifo_write,
    output logic [28:0] data,
    output logic        o_overflow,
    output logic [15:0] o_drop_cnt
);

    localparam logic [11:0] ACTIVE_W = 12'(ACTIVE_WIDTH);
    localparam logic [11:0] HALF_W   = 12'(HALF_WIDTH);
    localparam logic [10:0] MAX_L    = 11'(MAX_LINES);

    // Coefficients ordered {Y: R,G,B}, {Cb: R,G,B}, {Cr: R,G,B}
    localparam logic signed [17:0] COEF [9] = '{
        18'sd66,  18'sd129, 18'sd25,
        -18'sd38, -18'sd74, 18'sd112,
        18'sd112, -18'sd94, -18'sd18
    };
    localparam logic signed [17:0] OFFS [3] = '{18'sd16, 18'sd128, 18'sd128};

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_WAIT_LINE,
        ST_ACTIVE
    } state_t;

    function automatic logic [7:0] clamp8(input logic signed [17:0] v);
        if (v < 18'sd0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    // -----------------------------------------------------------------------
    // Timing FSM
    // -----------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        vsync_prev_q;
    logic [10:0] line_q, line_d;
    logic [11:0] pixel_q, pixel_d;
    logic        parity_q, parity_d;
    logic        vsync_rise;
    logic        frame_start;
    logic        pix_take;
    logic [11:0] pix_idx;
    logic        pix_valid;

    assign vsync_rise = i_vsync & ~vsync_prev_q;

    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            state_q      <= ST_SYNC;
            vsync_prev_q <= 1'b0;
            line_q       <= '0;
            pixel_q      <= '0;
            parity_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_prev_q <= i_vsync;
            line_q       <= line_d;
            pixel_q      <= pixel_d;
            parity_q     <= parity_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (vsync_rise)
                    state_d = ST_WAIT_LINE;
            end
            ST_WAIT_LINE: begin
                if (vsync_rise)
                    state_d = ST_WAIT_LINE;
                else if (i_de)
                    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // A vsync edge mid-line aborts the line; words already in
                // the pipeline still drain.
                if (vsync_rise || !i_de)
                    state_d = ST_WAIT_LINE;
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        line_d      = line_q;
        pixel_d     = pixel_q;
        parity_d    = parity_q;
        frame_start = 1'b0;
        pix_take    = 1'b0;
        pix_idx     = pixel_q;
        case (state_q)
            ST_SYNC: begin
                if (vsync_rise)
                    frame_start = 1'b1;
            end
            ST_WAIT_LINE: begin
                if (vsync_rise) begin
                    frame_start = 1'b1;
                end else if (i_de) begin
                    // First DE cycle is pixel 0 of the line
                    pix_take = 1'b1;
                    pix_idx  = 12'd0;
                    pixel_d  = 12'd1;
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise) begin
                    frame_start = 1'b1;
                end else if (i_de) begin
                    pix_take = 1'b1;
                    pix_idx  = pixel_q;
                    pixel_d  = (pixel_q == 12'hFFF) ? pixel_q : pixel_q + 12'd1;
                end else begin
                    line_d = (line_q == 11'h7FF) ? line_q : line_q + 11'd1;
                end
            end
            default: ;
        endcase
        if (frame_start) begin
            line_d   = '0;
            parity_d = ~parity_q;
        end
    end

    assign pix_valid = pix_take && (pix_idx < ACTIVE_W) && (line_q < MAX_L);

    // -----------------------------------------------------------------------
    // Stage 1: products
    // -----------------------------------------------------------------------
    logic [7:0]         rgb [3];
    logic signed [17:0] prod_d [9];
    logic signed [17:0] prod_q [9];
    logic               s1_valid_q;
    logic               s1_even_q;
    logic               s1_xblk_q;
    logic [10:0]        s1_line_q;
    logic               s1_par_q;

    assign rgb[0] = i_r;
    assign rgb[1] = i_g;
    assign rgb[2] = i_b;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_prod
            assign prod_d[gi] = COEF[gi] * $signed({10'd0, rgb[gi % 3]});
        end
    endgenerate

    always_ff @(posedge i_clk_74M) begin
        if (i_rst)
            s1_valid_q <= 1'b0;
        else
            s1_valid_q <= pix_valid;
    end

    always_ff @(posedge i_clk_74M) begin
        for (int k = 0; k < 9; k++)
            prod_q[k] <= prod_d[k];
        s1_even_q <= ~pix_idx[0];
        s1_xblk_q <= (pix_idx >= HALF_W);
        s1_line_q <= line_q;
        s1_par_q  <= parity_q;
    end

    // -----------------------------------------------------------------------
    // Stage 2: sums, rounding shift, offset and clamp
    // -----------------------------------------------------------------------
    logic [7:0]  comp_d [3];
    logic [7:0]  comp_q [3];   // 0 = Y, 1 = Cb, 2 = Cr
    logic        s2_valid_q;
    logic        s2_even_q;
    logic        s2_xblk_q;
    logic [10:0] s2_line_q;
    logic        s2_par_q;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_comp
            logic signed [17:0] sum_w;
            logic signed [17:0] adj_w;
            assign sum_w = prod_q[3*gi] + prod_q[3*gi+1] + prod_q[3*gi+2] + 18'sd128;
            assign adj_w = (sum_w >>> 8) + OFFS[gi];
            assign comp_d[gi] = clamp8(adj_w);
        end
    endgenerate

    always_ff @(posedge i_clk_74M) begin
        if (i_rst)
            s2_valid_q <= 1'b0;
        else
            s2_valid_q <= s1_valid_q;
    end

    always_ff @(posedge i_clk_74M) begin
        for (int k = 0; k < 3; k++)
            comp_q[k] <= comp_d[k];
        s2_even_q <= s1_even_q;
        s2_xblk_q <= s1_xblk_q;
        s2_line_q <= s1_line_q;
        s2_par_q  <= s1_par_q;
    end

    // -----------------------------------------------------------------------
    // Word assembly (optionally through the chroma averaging stage)
    // -----------------------------------------------------------------------
    logic [28:0] word_d;
    logic        out_valid;

`ifdef CHROMA_AVG_EN
    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    logic        s3_valid_q;
    logic        s3_even_q;
    logic        s3_xblk_q;
    logic [10:0] s3_line_q;
    logic        s3_par_q;
    logic [7:0]  s3_y_q;
    logic [7:0]  s3_cb_q;
    logic [7:0]  s3_cr_q;
    logic        even_ok_q;    // previous stage-3 word was an even pixel with a partner
    logic [7:0]  even_cb_q;    // that even pixel's Cb, consumed by its odd partner
    logic        pair_next;
    logic [7:0]  chroma;

    // Pixels of a line arrive on consecutive cycles, so an odd pixel directly
    // behind an even one is always its partner.
    assign pair_next = s3_valid_q && s3_even_q && s2_valid_q && !s2_even_q;

    always_comb begin
        if (s3_even_q)
            chroma = pair_next ? avg8(s3_cr_q, comp_q[2]) : s3_cr_q;
        else
            chroma = even_ok_q ? avg8(even_cb_q, s3_cb_q) : s3_cb_q;
    end

    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            s3_valid_q <= 1'b0;
            even_ok_q  <= 1'b0;
        end else begin
            s3_valid_q <= s2_valid_q;
            even_ok_q  <= pair_next;
        end
    end

    always_ff @(posedge i_clk_74M) begin
        s3_even_q <= s2_even_q;
        s3_xblk_q <= s2_xblk_q;
        s3_line_q <= s2_line_q;
        s3_par_q  <= s2_par_q;
        s3_y_q    <= comp_q[0];
        s3_cb_q   <= comp_q[1];
        s3_cr_q   <= comp_q[2];
        even_cb_q <= s3_cb_q;
    end

    assign word_d    = {s3_par_q, s3_xblk_q, s3_line_q, s3_y_q, chroma};
    assign out_valid = s3_valid_q;
`else
    assign word_d    = {s2_par_q, s2_xblk_q, s2_line_q, comp_q[0],
                        s2_even_q ? comp_q[2] : comp_q[1]};
    assign out_valid = s2_valid_q;
`endif

    // -----------------------------------------------------------------------
    // Final stage: FIFO write or drop
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            fifo_write <= 1'b0;
            data       <= '0;
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            fifo_write <= out_valid & ~fifo_full;
            if (out_valid && !fifo_full)
                data <= word_d;
            // A drop in the frame-start cycle belongs to the old frame's
            // tail but is still reported, so setting wins over clearing.
            if (out_valid && fifo_full) begin
                o_overflow <= 1'b1;
                if (o_drop_cnt != 16'hFFFF)
                    o_drop_cnt <= o_drop_cnt + 16'd1;
            end else if (frame_start) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule
